// File: rtl/ecc_pkg.sv
// Shared definitions for the SECDED-protected SRAM: codeword sizing helpers,
// Hamming position maps and the scrub FSM state type.
package ecc_pkg;

    typedef enum logic {
        IDLE,
        SCRUB
    } scrub_state_t;

    function automatic int calc_par_bits(input int data_width);
        int p;
        p = 1;
        while ((1 << p) < data_width + p + 1) p++;
        return p;
    endfunction

    function automatic int calc_cw_width(input int data_width);
        return data_width + calc_par_bits(data_width) + 1;
    endfunction

    // Codeword position 0 is overall parity, powers of two are Hamming parity,
    // every other position carries a data bit in ascending order.
    function automatic int data_idx(input int pos);
        return pos - 1 - $clog2(pos + 1);
    endfunction

    function automatic logic [63:0] cover_mask(input int p);
        logic [63:0] m;
        m = '0;
        for (int pos = 1; pos < 64; pos++) begin
            if (((pos >> p) & 1) != 0) m[pos] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ecc_secded.sv
// Combinational SECDED encoder (data_in -> cw_out) and decoder
// (cw_in -> corrected data_out plus sec/ded classification).
module ecc_secded
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    localparam int PAR_BITS = calc_par_bits(DATA_WIDTH),
    localparam int CW_WIDTH = DATA_WIDTH + PAR_BITS + 1
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CW_WIDTH-1:0]   cw_in,
    output logic [CW_WIDTH-1:0]   cw_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  sec,
    output logic                  ded
);

    localparam logic [PAR_BITS-1:0] SYN_MAX = PAR_BITS'(CW_WIDTH - 1);

    logic [CW_WIDTH-1:0] spread;
    logic [CW_WIDTH-1:0] enc_body;
    logic [CW_WIDTH-1:0] flip;
    logic [CW_WIDTH-1:0] fixed_cw;
    logic [PAR_BITS-1:0] par;
    logic [PAR_BITS-1:0] syn;
    logic                parity_err;

    genvar gi;
    generate
        for (gi = 0; gi < CW_WIDTH; gi++) begin : g_pos
            if (gi != 0 && (gi & (gi - 1)) != 0) begin : g_data
                assign spread[gi]             = data_in[data_idx(gi)];
                assign enc_body[gi]           = data_in[data_idx(gi)];
                assign data_out[data_idx(gi)] = fixed_cw[gi];
            end else if (gi != 0) begin : g_par
                assign spread[gi]   = 1'b0;
                assign enc_body[gi] = par[$clog2(gi)];
            end else begin : g_overall
                assign spread[gi]   = 1'b0;
                assign enc_body[gi] = 1'b0;
            end
            assign flip[gi] = sec && (syn == PAR_BITS'(gi));
        end

        for (gi = 0; gi < PAR_BITS; gi++) begin : g_syn
            localparam logic [CW_WIDTH-1:0] COVER = CW_WIDTH'(cover_mask(gi));
            assign par[gi] = ^(spread & COVER);
            assign syn[gi] = ^(cw_in & COVER);
        end
    endgenerate

    // enc_body[0] is zero, so the full reduction is the parity of the rest.
    assign cw_out = {enc_body[CW_WIDTH-1:1], ^enc_body};

    assign parity_err = ^cw_in;
    assign sec        = parity_err && (syn <= SYN_MAX);
    assign ded        = (syn > SYN_MAX) || (!parity_err && syn != '0);
    // flip is all-zero on DED, so data_out then carries the raw stored bits.
    assign fixed_cw   = cw_in ^ flip;

endmodule

// File: rtl/ecc_sram.sv
// Single-port synchronous SRAM with SECDED protection, pipelined reads,
// error reporting/counting and optional one-cycle scrub of corrected words.
module ecc_sram
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int CNT_WIDTH  = 8,
    parameter int WRITEBACK  = 1,
    localparam int PAR_BITS  = calc_par_bits(DATA_WIDTH),
    localparam int CW_WIDTH  = calc_cw_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CSb,
    input  logic                  WEb,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic [CW_WIDTH-1:0]   INJ_MASK,
    output logic                  READY,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  RVALID,
    output logic                  SEC_ERR,
    output logic                  DED_ERR,
    output logic [ADDR_WIDTH-1:0] ERR_ADDR,
    output logic [CNT_WIDTH-1:0]  SEC_COUNT,
    output logic [CNT_WIDTH-1:0]  DED_COUNT
);

    logic [CW_WIDTH-1:0]   mem [RAM_DEPTH];
    logic [CW_WIDTH-1:0]   stage_cw_reg;
    logic                  stage_valid_reg;
    logic [ADDR_WIDTH-1:0] stage_addr_reg;
    logic [DATA_WIDTH-1:0] scrub_data_reg;
    logic [ADDR_WIDTH-1:0] scrub_addr_reg;
    scrub_state_t          state_reg, state_next;

    logic [DATA_WIDTH-1:0] dout_reg;
    logic                  rvalid_reg, sec_reg, ded_reg;
    logic [ADDR_WIDTH-1:0] err_addr_reg;
    logic [CNT_WIDTH-1:0]  sec_cnt_reg, ded_cnt_reg;

    logic                  accept, do_write, do_read, start_scrub;
    logic [DATA_WIDTH-1:0] enc_data, dec_data;
    logic [CW_WIDTH-1:0]   enc_cw;
    logic                  dec_sec, dec_ded;

    assign accept   = !CSb && READY;
    assign do_write = accept && !WEb;
    assign do_read  = accept && WEb;

    // The single encoder is shared: no request is accepted during SCRUB.
    assign enc_data = (state_reg == SCRUB) ? scrub_data_reg : DIN;

    ecc_secded #(.DATA_WIDTH(DATA_WIDTH)) u_secded (
        .data_in (enc_data),
        .cw_in   (stage_cw_reg),
        .cw_out  (enc_cw),
        .data_out(dec_data),
        .sec     (dec_sec),
        .ded     (dec_ded)
    );

    assign start_scrub = stage_valid_reg && dec_sec && (WRITEBACK != 0) && (state_reg == IDLE);

    always_comb begin
        state_next = state_reg;
        READY      = 1'b0;
        case (state_reg)
            IDLE: begin
                READY = 1'b1;
                if (start_scrub) state_next = SCRUB;
            end
            SCRUB:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == SCRUB) mem[scrub_addr_reg] <= enc_cw;
            else if (do_write)      mem[ADDR] <= enc_cw ^ INJ_MASK;
            if (do_read) stage_cw_reg <= mem[ADDR];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_reg <= 1'b0;
            stage_addr_reg  <= '0;
            scrub_data_reg  <= '0;
            scrub_addr_reg  <= '0;
            dout_reg        <= '0;
            rvalid_reg      <= 1'b0;
            sec_reg         <= 1'b0;
            ded_reg         <= 1'b0;
            err_addr_reg    <= '0;
            sec_cnt_reg     <= '0;
            ded_cnt_reg     <= '0;
        end else begin
            stage_valid_reg <= do_read;
            if (do_read) stage_addr_reg <= ADDR;
            rvalid_reg <= stage_valid_reg;
            sec_reg    <= stage_valid_reg && dec_sec;
            ded_reg    <= stage_valid_reg && dec_ded;
            if (stage_valid_reg) dout_reg <= dec_data;
            if (stage_valid_reg && (dec_sec || dec_ded)) err_addr_reg <= stage_addr_reg;
            if (stage_valid_reg && dec_sec && sec_cnt_reg != '1) sec_cnt_reg <= sec_cnt_reg + 1'b1;
            if (stage_valid_reg && dec_ded && ded_cnt_reg != '1) ded_cnt_reg <= ded_cnt_reg + 1'b1;
            if (start_scrub) begin
                scrub_data_reg <= dec_data;
                scrub_addr_reg <= stage_addr_reg;
            end
        end
    end

    assign DOUT      = dout_reg;
    assign RVALID    = rvalid_reg;
    assign SEC_ERR   = sec_reg;
    assign DED_ERR   = ded_reg;
    assign ERR_ADDR  = err_addr_reg;
    assign SEC_COUNT = sec_cnt_reg;
    assign DED_COUNT = ded_cnt_reg;

endmodule

// File: tb/tb_ecc_sram.sv
// Directed bench for ecc_sram: table of write/inject/read vectors plus
// hand-written sequences for scrub, streaming, drop, reset and saturation.
module tb_ecc_sram;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CW = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          csb, web;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [CW-1:0] inj;
    logic          ready, rvalid, sec_err, ded_err;
    logic [DW-1:0] dout;
    logic [AW-1:0] err_addr;
    logic [7:0]    sec_count, ded_count;

    logic          csb2, web2;
    logic [AW-1:0] addr2;
    logic [DW-1:0] din2;
    logic [CW-1:0] inj2;
    logic          ready2, rvalid2, sec_err2, ded_err2;
    logic [DW-1:0] dout2;
    logic [AW-1:0] err_addr2;
    logic [1:0]    sec_count2, ded_count2;

    ecc_sram dut (
        .clk(clk), .rst(rst), .CSb(csb), .WEb(web), .ADDR(addr), .DIN(din),
        .INJ_MASK(inj), .READY(ready), .DOUT(dout), .RVALID(rvalid),
        .SEC_ERR(sec_err), .DED_ERR(ded_err), .ERR_ADDR(err_addr),
        .SEC_COUNT(sec_count), .DED_COUNT(ded_count)
    );

    ecc_sram #(.CNT_WIDTH(2), .WRITEBACK(0)) dut2 (
        .clk(clk), .rst(rst), .CSb(csb2), .WEb(web2), .ADDR(addr2), .DIN(din2),
        .INJ_MASK(inj2), .READY(ready2), .DOUT(dout2), .RVALID(rvalid2),
        .SEC_ERR(sec_err2), .DED_ERR(ded_err2), .ERR_ADDR(err_addr2),
        .SEC_COUNT(sec_count2), .DED_COUNT(ded_count2)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [CW-1:0] m;
        logic [DW-1:0] exp_d;
        logic          exp_sec;
        logic          exp_ded;
    } vec_t;

    vec_t tbl[9];
    int   n_vec = 0;
    int   n_miss = 0;
    int   exp_sec = 0;
    int   exp_ded = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [CW-1:0] m);
        @(negedge clk);
        csb = 1'b0; web = 1'b0; addr = a; din = d; inj = m;
        @(negedge clk);
        csb = 1'b1; web = 1'b1; inj = '0;
    endtask

    // Returns 1 ns after the response edge (one edge after acceptance).
    task automatic rd(input logic [AW-1:0] a);
        @(negedge clk);
        csb = 1'b0; web = 1'b1; addr = a;
        @(negedge clk);
        csb = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'd3,  8'hA5, 13'h0000, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{4'd5,  8'h3C, 13'h0010, 8'h3C, 1'b1, 1'b0};
        tbl[2] = '{4'd7,  8'h81, 13'h0003, 8'h81, 1'b0, 1'b1};
        tbl[3] = '{4'd8,  8'h55, 13'h0008, 8'h55, 1'b1, 1'b0};
        tbl[4] = '{4'd9,  8'h0F, 13'h0001, 8'h0F, 1'b1, 1'b0};
        tbl[5] = '{4'd10, 8'h00, 13'h0028, 8'h03, 1'b0, 1'b1};
        tbl[6] = '{4'd11, 8'hFF, 13'h1000, 8'hFF, 1'b1, 1'b0};
        tbl[7] = '{4'd12, 8'h80, 13'h1003, 8'h00, 1'b0, 1'b1};
        tbl[8] = '{4'd13, 8'h00, 13'h0000, 8'h00, 1'b0, 1'b0};

        rst = 1'b1; csb = 1'b1; web = 1'b1; addr = '0; din = '0; inj = '0;
        csb2 = 1'b1; web2 = 1'b1; addr2 = '0; din2 = '0; inj2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset READY", 32'(ready), 1);
        check("reset RVALID", 32'(rvalid), 0);
        check("reset DOUT", 32'(dout), 0);
        check("reset flags", 32'({sec_err, ded_err}), 0);
        check("reset ERR_ADDR", 32'(err_addr), 0);
        check("reset counters", 32'({sec_count, ded_count}), 0);

        for (int i = 0; i < 9; i++) begin
            wr(tbl[i].a, tbl[i].d, tbl[i].m);
            rd(tbl[i].a);
            check($sformatf("vec%0d RVALID", i), 32'(rvalid), 1);
            check($sformatf("vec%0d DOUT", i), 32'(dout), 32'(tbl[i].exp_d));
            check($sformatf("vec%0d SEC_ERR", i), 32'(sec_err), 32'(tbl[i].exp_sec));
            check($sformatf("vec%0d DED_ERR", i), 32'(ded_err), 32'(tbl[i].exp_ded));
            check($sformatf("vec%0d READY", i), 32'(ready), 32'(!tbl[i].exp_sec));
            if (tbl[i].exp_sec) exp_sec++;
            if (tbl[i].exp_ded) exp_ded++;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d RVALID pulse", i), 32'(rvalid), 0);
            check($sformatf("vec%0d READY after", i), 32'(ready), 1);
        end
        check("table SEC_COUNT", 32'(sec_count), 32'(exp_sec));
        check("table DED_COUNT", 32'(ded_count), 32'(exp_ded));
        check("table ERR_ADDR", 32'(err_addr), 12);

        // Scrubbed words now read clean; DED word stays bad
        rd(4'd5);
        check("reread5 SEC_ERR", 32'(sec_err), 0);
        check("reread5 DOUT", 32'(dout), 32'h3C);
        rd(4'd8);
        check("reread8 SEC_ERR", 32'(sec_err), 0);
        check("reread8 DOUT", 32'(dout), 32'h55);
        rd(4'd7);
        exp_ded++;
        check("reread7 DED_ERR", 32'(ded_err), 1);
        check("reread7 DOUT", 32'(dout), 32'h81);
        check("reread7 DED_COUNT", 32'(ded_count), 32'(exp_ded));

        // Streaming reads
        for (int i = 0; i < 16; i++) wr(AW'(i), DW'(i * 17), '0);
        @(negedge clk);
        csb = 1'b0; web = 1'b1; addr = '0;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            if (i < 16) addr = AW'(i);
            else csb = 1'b1;
            if (i >= 2) begin
                check($sformatf("stream%0d RVALID", i - 2), 32'(rvalid), 1);
                check($sformatf("stream%0d DOUT", i - 2), 32'(dout), 32'((i - 2) * 17));
                check($sformatf("stream%0d READY", i - 2), 32'(ready), 1);
            end
        end
        @(posedge clk);
        #1;
        check("stream end RVALID", 32'(rvalid), 0);

        // Back-to-back SEC reads: only the first schedules a scrub
        wr(4'd2, 8'h12, 13'h0008);
        wr(4'd4, 8'h34, 13'h0008);
        @(negedge clk);
        csb = 1'b0; web = 1'b1; addr = 4'd2;
        @(posedge clk);
        #1;
        addr = 4'd4;
        @(posedge clk);
        #1;
        csb = 1'b1;
        check("pipe first SEC_ERR", 32'(sec_err), 1);
        check("pipe first DOUT", 32'(dout), 32'h12);
        check("pipe first READY", 32'(ready), 0);
        @(posedge clk);
        #1;
        exp_sec += 2;
        check("pipe second SEC_ERR", 32'(sec_err), 1);
        check("pipe second DOUT", 32'(dout), 32'h34);
        check("pipe second READY", 32'(ready), 1);
        check("pipe SEC_COUNT", 32'(sec_count), 32'(exp_sec));
        check("pipe ERR_ADDR", 32'(err_addr), 4);
        rd(4'd4);
        exp_sec++;
        check("pipe reread4 SEC_ERR", 32'(sec_err), 1);
        @(posedge clk);
        #1;
        rd(4'd2);
        check("pipe reread2 SEC_ERR", 32'(sec_err), 0);
        check("pipe reread2 DOUT", 32'(dout), 32'h12);
        rd(4'd4);
        check("pipe scrub4 SEC_ERR", 32'(sec_err), 0);

        // Write presented during SCRUB is dropped
        wr(4'd6, 8'h11, '0);
        wr(4'd15, 8'h22, 13'h0008);
        rd(4'd15);
        exp_sec++;
        check("drop SEC_ERR", 32'(sec_err), 1);
        check("drop READY", 32'(ready), 0);
        wr(4'd6, 8'h99, '0);
        rd(4'd6);
        check("drop DOUT", 32'(dout), 32'h11);
        check("drop SEC_COUNT", 32'(sec_count), 32'(exp_sec));
        check("drop ERR_ADDR", 32'(err_addr), 15);

        // Reset in the SCRUB cycle abandons the writeback
        wr(4'd14, 8'h5A, 13'h0040);
        rd(4'd14);
        check("rstscrub SEC_ERR", 32'(sec_err), 1);
        check("rstscrub READY low", 32'(ready), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstscrub READY", 32'(ready), 1);
        check("rstscrub RVALID", 32'(rvalid), 0);
        check("rstscrub counters", 32'({sec_count, ded_count}), 0);
        check("rstscrub ERR_ADDR", 32'(err_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_sec = 0;
        exp_ded = 0;
        rd(4'd14);
        exp_sec++;
        check("rstscrub reread SEC_ERR", 32'(sec_err), 1);
        check("rstscrub reread DOUT", 32'(dout), 32'h5A);
        check("rstscrub reread SEC_COUNT", 32'(sec_count), 32'(exp_sec));
        @(posedge clk);
        #1;

        // Saturating 2-bit counter, no writeback
        @(negedge clk);
        csb2 = 1'b0; web2 = 1'b0; addr2 = 4'd1; din2 = 8'h77; inj2 = 13'h0008;
        @(negedge clk);
        web2 = 1'b1; inj2 = '0;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) csb2 = 1'b1;
            check($sformatf("sat%0d SEC_ERR", k), 32'(sec_err2), 1);
            check($sformatf("sat%0d DOUT", k), 32'(dout2), 32'h77);
            check($sformatf("sat%0d READY", k), 32'(ready2), 1);
            check($sformatf("sat%0d SEC_COUNT", k), 32'(sec_count2), 32'((k < 3) ? k : 3));
        end
        check("sat DED_COUNT", 32'(ded_count2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ecc_sram.md
Name: ecc_sram

Overview:
Parametrised single-port synchronous SRAM model with SECDED (Hamming plus overall parity) protection. Replaces the plain fixed-size SRAM model in compiler-generated designs. The data bus is split into separate input and output buses. Reads are pipelined and report single/double-bit errors, and single-bit errors are optionally scrubbed back to the array. An error-injection port lets benches corrupt stored codewords.

Parameters:
- DATA_WIDTH, 8, payload bits per word.
- ADDR_WIDTH, 4, address bits.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words.
- CNT_WIDTH, 8, width of the saturating error counters.
- WRITEBACK, 1, 1 = scrub corrected words back to the array on a single-bit error.
- Derived PAR_BITS = smallest P with 2^P >= DATA_WIDTH+P+1.
- Derived CW_WIDTH = DATA_WIDTH+PAR_BITS+1 (13 for the defaults).

Ports:
- clk  in  1  clock; all activity on the rising edge.
- rst  in  1  synchronous, active-high reset.
- CSb  in  1  active-low chip select.
- WEb  in  1  active-low write enable (0 = write, 1 = read).
- ADDR  in  ADDR_WIDTH  word address.
- DIN  in  DATA_WIDTH  write data.
- INJ_MASK  in  CW_WIDTH  XOR mask applied to the encoded codeword on write; 0 in normal use.
- READY  out  1  request accepted at this edge when 1.
- DOUT  out  DATA_WIDTH  read data (corrected where possible).
- RVALID  out  1  DOUT and the error flags are valid this cycle.
- SEC_ERR  out  1  response had a corrected single-bit error.
- DED_ERR  out  1  response had an uncorrectable double-bit error.
- ERR_ADDR  out  ADDR_WIDTH  address of the most recent SEC or DED response.
- SEC_COUNT  out  CNT_WIDTH  saturating count of SEC responses.
- DED_COUNT  out  CNT_WIDTH  saturating count of DED responses.

Behaviour:
- Reset values: READY=1, DOUT=0, RVALID=0, SEC_ERR=0, DED_ERR=0, ERR_ADDR=0, counters=0, FSM=IDLE. The array is not cleared.
- Acceptance: a request is accepted at edge E0 when CSb=0 and READY=1. Requests presented while READY=0 are ignored and dropped, not queued.
- Write at E0: mem[ADDR] <= encode(DIN) ^ INJ_MASK. No response is produced.
- Read at E0: the codeword is latched into the stage register at E0. At E1 the decode result is registered: DOUT, RVALID=1, SEC_ERR, DED_ERR.
- Read latency is 1 cycle after the acceptance edge. Reads are fully pipelined, one per cycle, with RVALID continuous.
- RVALID and the flags are single-cycle pulses per response. With no response, RVALID=0 and both flags are 0; DOUT holds its last value.
- Decode, clean word: syndrome 0 and overall parity OK → data as stored, no flags.
- Decode, single-bit error: syndrome nonzero with overall parity wrong → flip the indicated bit and set SEC_ERR. A syndrome of 0 with parity wrong means the parity bit itself is in error: data is unchanged and SEC_ERR is still set.
- Decode, double-bit error: syndrome nonzero with overall parity OK → DOUT = raw stored data bits, DED_ERR=1, no writeback.
- Syndrome out of range (>CW_WIDTH-1) is treated as DED.
- Counters: ERR_ADDR updates on every SEC or DED response. Counters increment by 1 per flagged response and saturate at all-ones.
- FSM IDLE→SCRUB: at E1, when SEC is detected with WRITEBACK=1 and FSM=IDLE, the corrected codeword and address are held and FSM goes to SCRUB.
- FSM SCRUB: READY=0 for exactly one cycle. At the next edge the array is written with the corrected codeword and FSM returns to IDLE.
- A read accepted in the cycle before SCRUB still completes. If it also reports SEC, flags and counters update but no second writeback is scheduled.
- rst has priority over everything. Reset during SCRUB abandons the writeback and performs no array write on the reset edge. A pending read response is discarded.

Decomposition:
- ecc_pkg: function computing PAR_BITS from DATA_WIDTH; CW_WIDTH helper; FSM state enum {IDLE, SCRUB}.
- One sub-module, ecc_secded: purely combinational encoder and decoder, parametrised on DATA_WIDTH. Outputs: codeword, corrected data, sec, ded.
- ecc_sram holds the array, pipeline stage, FSM and counters.

Test Plan:
- Clean read: reset, write 0xA5 @3, read @3 → one cycle after acceptance DOUT=0xA5, RVALID=1, SEC_ERR=0, DED_ERR=0, READY stays 1.
- Single-bit error: write 0x3C @5 with INJ_MASK=0x0010, read @5 → DOUT=0x3C, SEC_ERR=1, SEC_COUNT=1, ERR_ADDR=5, READY=0 for one cycle. Re-read @5 → SEC_ERR=0, proving the scrub.
- Double-bit error: write 0x81 @7 with INJ_MASK=0x0003, read @7 → DED_ERR=1, DED_COUNT=1, DOUT=raw data bits, READY stays 1. Re-read → DED_ERR=1 again, DED_COUNT=2.
- Streaming reads: write @0..15 with data = addr*17, then read @0..15 back-to-back → 16 consecutive RVALID cycles with matching data, in order.
- Saturation and drop: CNT_WIDTH=2, WRITEBACK=0, five SEC reads → SEC_COUNT=3. A write presented while READY=0 (WRITEBACK=1 run) → array unchanged.
- Reset mid-scrub: assert rst in the SCRUB cycle → READY=1, counters=0, RVALID=0 next cycle. The word still reads back with SEC_ERR=1, proving no writeback occurred.
